instr_decode_unit: RTL and testbench

- Decode stage of the 16-bit, 4-bit-opcode datapath.
- Takes the opcode and the pre-extracted immediate fields (imm7, nzimm6, offset9) from fetch.
- Produces registered datapath control signals, the ALU operation code, a forwarded opcode, and the reassembled 16-bit instruction word for the next pipeline stage.
- Outputs update on the clock edge after the inputs are presented.

---
 rtl/instr_decode_unit.sv | 171 +++++++++++++++++
 tb/tb_instr_decode_unit.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/instr_decode_unit.sv
// Decode stage for the 16-bit, 4-bit-opcode datapath.
// Combinational decode of opcode and immediate fields, then one register stage.
// Every output is a flop, so results appear exactly one cycle after the inputs.
module instr_decode_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  opcode_in,
    input  logic [6:0]  immediate,
    input  logic [5:0]  nzimm,
    input  logic [8:0]  offset,
    output logic        RegWrite,
    output logic        RegDst,
    output logic        ALUSrc1,
    output logic        ALUSrc2,
    output logic        MemWrite,
    output logic        MemToReg,
    output logic        RegSrc,
    output logic [3:0]  opcode_out,
    output logic [3:0]  ALUOp,
    output logic [15:0] instr_i
);

    // ALU operation codes
    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b0001;
    localparam logic [3:0] ALU_AND   = 4'b0010;
    localparam logic [3:0] ALU_OR    = 4'b0011;
    localparam logic [3:0] ALU_SLT   = 4'b0100;
    localparam logic [3:0] ALU_PASSB = 4'b0101;

    // Opcodes
    localparam logic [3:0] OP_ADDI = 4'b0000;
    localparam logic [3:0] OP_ANDI = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_LUI  = 4'b0011;
    localparam logic [3:0] OP_SUB  = 4'b0100;
    localparam logic [3:0] OP_SLTI = 4'b0101;
    localparam logic [3:0] OP_AND  = 4'b0110;
    localparam logic [3:0] OP_OR   = 4'b0111;
    localparam logic [3:0] OP_LW   = 4'b1000;
    localparam logic [3:0] OP_SW   = 4'b1001;
    localparam logic [3:0] OP_BEQ  = 4'b1010;
    localparam logic [3:0] OP_J    = 4'b1011;

    // Control vector ordering: {RegWrite, RegDst, ALUSrc1, ALUSrc2, MemWrite, MemToReg, RegSrc}
    localparam logic [6:0] CTRL_IMM  = 7'b1001000;
    localparam logic [6:0] CTRL_REG  = 7'b1100000;
    localparam logic [6:0] CTRL_LW   = 7'b1001010;
    localparam logic [6:0] CTRL_SW   = 7'b0001101;
    localparam logic [6:0] CTRL_BEQ  = 7'b0000000;
    localparam logic [6:0] CTRL_J    = 7'b0011000;
    localparam logic [6:0] CTRL_NOP  = 7'b0000000;

    logic [6:0]  ctrl_next;
    logic [3:0]  alu_op_next;
    logic [15:0] instr_next;
    logic        nz_valid;

    logic [6:0]  ctrl_reg;
    logic [3:0]  alu_op_reg;
    logic [3:0]  opcode_reg;
    logic [15:0] instr_reg;

    assign nz_valid = (nzimm != 6'd0);

    // Decode the opcode into control bits, ALU op and reassembled instruction word
    always_comb begin
        ctrl_next   = CTRL_NOP;
        alu_op_next = ALU_ADD;
        instr_next  = {opcode_in, 12'b0};
        case (opcode_in)
            OP_ADDI: begin
                ctrl_next   = CTRL_IMM;
                alu_op_next = ALU_ADD;
                instr_next  = {opcode_in, 5'b0, immediate};
            end
            OP_ANDI: begin
                ctrl_next   = CTRL_IMM;
                alu_op_next = ALU_AND;
                instr_next  = {opcode_in, 5'b0, immediate};
            end
            OP_SLTI: begin
                ctrl_next   = CTRL_IMM;
                alu_op_next = ALU_SLT;
                instr_next  = {opcode_in, 5'b0, immediate};
            end
            OP_ADD: begin
                ctrl_next   = CTRL_REG;
                alu_op_next = ALU_ADD;
            end
            OP_SUB: begin
                ctrl_next   = CTRL_REG;
                alu_op_next = ALU_SUB;
            end
            OP_AND: begin
                ctrl_next   = CTRL_REG;
                alu_op_next = ALU_AND;
            end
            OP_OR: begin
                ctrl_next   = CTRL_REG;
                alu_op_next = ALU_OR;
            end
            // N-format: a zero nzimm is illegal and decodes as NOP, but the
            // instruction word is still assembled from the (zero) field.
            OP_LUI: begin
                instr_next = {opcode_in, 6'b0, nzimm};
                if (nz_valid) begin
                    ctrl_next   = CTRL_IMM;
                    alu_op_next = ALU_PASSB;
                end
            end
            OP_LW: begin
                instr_next = {opcode_in, 6'b0, nzimm};
                if (nz_valid) begin
                    ctrl_next   = CTRL_LW;
                    alu_op_next = ALU_ADD;
                end
            end
            OP_SW: begin
                instr_next = {opcode_in, 6'b0, nzimm};
                if (nz_valid) begin
                    ctrl_next   = CTRL_SW;
                    alu_op_next = ALU_ADD;
                end
            end
            OP_BEQ: begin
                ctrl_next   = CTRL_BEQ;
                alu_op_next = ALU_SUB;
                instr_next  = {opcode_in, 3'b0, offset};
            end
            OP_J: begin
                ctrl_next   = CTRL_J;
                alu_op_next = ALU_ADD;
                instr_next  = {opcode_in, 3'b0, offset};
            end
            default: begin
                // 1100-1111: illegal, keep NOP defaults
                ctrl_next   = CTRL_NOP;
                alu_op_next = ALU_ADD;
                instr_next  = {opcode_in, 12'b0};
            end
        endcase
    end

    // Pipeline register; reset clears everything without waiting for a clock
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_reg   <= 7'd0;
            alu_op_reg <= 4'd0;
            opcode_reg <= 4'd0;
            instr_reg  <= 16'd0;
        end else begin
            ctrl_reg   <= ctrl_next;
            alu_op_reg <= alu_op_next;
            opcode_reg <= opcode_in;
            instr_reg  <= instr_next;
        end
    end

    assign RegWrite   = ctrl_reg[6];
    assign RegDst     = ctrl_reg[5];
    assign ALUSrc1    = ctrl_reg[4];
    assign ALUSrc2    = ctrl_reg[3];
    assign MemWrite   = ctrl_reg[2];
    assign MemToReg   = ctrl_reg[1];
    assign RegSrc     = ctrl_reg[0];
    assign ALUOp      = alu_op_reg;
    assign opcode_out = opcode_reg;
    assign instr_i    = instr_reg;

endmodule

// File: tb/tb_instr_decode_unit.sv
// Self-checking bench for instr_decode_unit: a table of vectors plus
// hand-written reset and back-to-back sequences, checked through a scoreboard.
module tb_instr_decode_unit;

    logic        clk;
    logic        rst_n;
    logic [3:0]  opcode_in;
    logic [6:0]  immediate;
    logic [5:0]  nzimm;
    logic [8:0]  offset;
    logic        RegWrite, RegDst, ALUSrc1, ALUSrc2, MemWrite, MemToReg, RegSrc;
    logic [3:0]  opcode_out;
    logic [3:0]  ALUOp;
    logic [15:0] instr_i;

    instr_decode_unit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .opcode_in  (opcode_in),
        .immediate  (immediate),
        .nzimm      (nzimm),
        .offset     (offset),
        .RegWrite   (RegWrite),
        .RegDst     (RegDst),
        .ALUSrc1    (ALUSrc1),
        .ALUSrc2    (ALUSrc2),
        .MemWrite   (MemWrite),
        .MemToReg   (MemToReg),
        .RegSrc     (RegSrc),
        .opcode_out (opcode_out),
        .ALUOp      (ALUOp),
        .instr_i    (instr_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ctrl ordering: {RW, RD, A1, A2, MW, MTR, RS}
    typedef struct {
        logic [3:0]  op;
        logic [6:0]  imm;
        logic [5:0]  nz;
        logic [8:0]  off;
        logic [6:0]  ctrl;
        logic [3:0]  alu;
        logic [15:0] instr;
    } vec_t;

    typedef struct {
        logic [6:0]  ctrl;
        logic [3:0]  alu;
        logic [3:0]  op;
        logic [15:0] instr;
    } exp_t;

    localparam int NVEC = 17;
    vec_t vecs [NVEC];
    exp_t sb_q [$];
    int   tests;
    int   fails;

    function automatic logic [6:0] ctrl_act();
        return {RegWrite, RegDst, ALUSrc1, ALUSrc2, MemWrite, MemToReg, RegSrc};
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one vector, push its expectation, then compare one cycle later
    task automatic apply(input vec_t v, input string tag);
        exp_t e;
        exp_t got;
        opcode_in = v.op;
        immediate = v.imm;
        nzimm     = v.nz;
        offset    = v.off;
        e.ctrl = v.ctrl; e.alu = v.alu; e.op = v.op; e.instr = v.instr;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        got = sb_q.pop_front();
        check({tag, " ctrl"},  {9'd0, ctrl_act()}, {9'd0, got.ctrl});
        check({tag, " aluop"}, {12'd0, ALUOp},     {12'd0, got.alu});
        check({tag, " opout"}, {12'd0, opcode_out},{12'd0, got.op});
        check({tag, " instr"}, instr_i,            got.instr);
        $display("[TB] op=%b ctrl=%b alu=%h instr=%h", v.op, ctrl_act(), ALUOp, instr_i);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " ctrl"},  {9'd0, ctrl_act()}, 16'd0);
        check({tag, " aluop"}, {12'd0, ALUOp},     16'd0);
        check({tag, " opout"}, {12'd0, opcode_out},16'd0);
        check({tag, " instr"}, instr_i,            16'd0);
    endtask

    // Cycle-budget watchdog
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        tests = 0;
        fails = 0;

        //            op     imm     nz     off      ctrl        alu    instr
        vecs[0]  = '{4'h0, 7'd10,  6'd0,  9'd0,   7'b1001000, 4'h0, 16'h000A};
        vecs[1]  = '{4'h1, 7'd10,  6'd0,  9'd0,   7'b1001000, 4'h2, 16'h100A};
        vecs[2]  = '{4'h2, 7'd0,   6'd0,  9'd0,   7'b1100000, 4'h0, 16'h2000};
        vecs[3]  = '{4'h3, 7'd0,   6'd10, 9'd0,   7'b1001000, 4'h5, 16'h300A};
        vecs[4]  = '{4'h4, 7'd0,   6'd0,  9'd0,   7'b1100000, 4'h1, 16'h4000};
        vecs[5]  = '{4'h5, 7'd10,  6'd0,  9'd0,   7'b1001000, 4'h4, 16'h500A};
        vecs[6]  = '{4'h6, 7'd0,   6'd0,  9'd0,   7'b1100000, 4'h2, 16'h6000};
        vecs[7]  = '{4'h7, 7'd0,   6'd0,  9'd0,   7'b1100000, 4'h3, 16'h7000};
        vecs[8]  = '{4'h8, 7'd0,   6'd10, 9'd0,   7'b1001010, 4'h0, 16'h800A};
        vecs[9]  = '{4'h9, 7'd0,   6'd10, 9'd0,   7'b0001101, 4'h0, 16'h900A};
        vecs[10] = '{4'hA, 7'd0,   6'd0,  9'd10,  7'b0000000, 4'h1, 16'hA00A};
        vecs[11] = '{4'hB, 7'd0,   6'd0,  9'd10,  7'b0011000, 4'h0, 16'hB00A};
        // illegal N-format with zero nzimm
        vecs[12] = '{4'h8, 7'd0,   6'd0,  9'd0,   7'b0000000, 4'h0, 16'h8000};
        vecs[13] = '{4'h3, 7'd99,  6'd0,  9'd300, 7'b0000000, 4'h0, 16'h3000};
        // illegal opcodes
        vecs[14] = '{4'hE, 7'd127, 6'd63, 9'd511, 7'b0000000, 4'h0, 16'hE000};
        vecs[15] = '{4'hF, 7'd1,   6'd1,  9'd1,   7'b0000000, 4'h0, 16'hF000};
        // unused fields must be ignored
        vecs[16] = '{4'hA, 7'd127, 6'd63, 9'd511, 7'b0000000, 4'h1, 16'hA1FF};

        // Reset asserted from time 0: outputs are zero before any clock edge
        rst_n     = 1'b0;
        opcode_in = 4'h0;
        immediate = 7'd10;
        nzimm     = 6'd0;
        offset    = 9'd0;
        #2;
        check_all_zero("reset_noclk");

        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            apply(vecs[i], $sformatf("vec%0d", i));
        end

        // Back-to-back ADD then SW with no bubble; fields of ADD nonzero
        apply('{4'h2, 7'd55, 6'd33, 9'd77, 7'b1100000, 4'h0, 16'h2000}, "b2b_add");
        apply('{4'h9, 7'd0,  6'd5,  9'd0,  7'b0001101, 4'h0, 16'h9005}, "b2b_sw");

        // Mid-stream asynchronous reset clears outputs before the next edge
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("reset_async");
        @(posedge clk);
        #1;
        check_all_zero("reset_held");
        @(negedge clk);
        rst_n = 1'b1;
        apply('{4'hB, 7'd0, 6'd0, 9'd3, 7'b0011000, 4'h0, 16'hB003}, "post_reset_j");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
